// File: rtl/wb_uart_if.sv
// rtl/wb_uart_if.sv - Wishbone B3 classic bus bundle between interconnect and wb_uart
interface wb_uart_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_uart.sv
// rtl/wb_uart.sv - Wishbone UART, 8N1 TX through a FIFO; receiver built only with MUSKOKA_UART_RX_EN
module wb_uart #(
    parameter int          TX_DEPTH_LOG2 = 3,
    parameter logic [15:0] DIV_RESET     = 16'd434
) (
    input  logic     clk_i,
    input  logic     rst_i,
    wb_uart_if.slave wb,
    output logic     tx_o,
    input  logic     rx_i,
    output logic     irq_o
);
    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {TX_DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Bus decode; register side effects happen only while ack is high
    logic        bus_req, ack_q, wr_cycle, rd_cycle;
    logic [1:0]  reg_sel;
    logic [31:0] rd_mux, rd_data_q;
    logic [15:0] div_q;

    assign bus_req  = wb.wb_cyc_i & wb.wb_stb_i;
    assign reg_sel  = wb.wb_adr_i[3:2];
    assign wr_cycle = ack_q & bus_req & wb.wb_we_i;
    assign rd_cycle = ack_q & bus_req & ~wb.wb_we_i;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = rd_data_q;

    // TX FIFO state
    logic [7:0]               fifo_mem [DEPTH];
    logic [TX_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [TX_DEPTH_LOG2:0]   count_q;
    logic                     tx_full, tx_empty, push_req, push, pop;

    assign tx_full  = (count_q == FULL_COUNT);
    assign tx_empty = (count_q == '0);
    assign push_req = wr_cycle & (reg_sel == 2'd0);
    // A pop in the same cycle frees a slot, so a push at full is still taken
    assign push     = push_req & (~tx_full | pop);

    // TX serialiser state
    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        bit_end, tx_busy;

    assign bit_end = (baud_q == 16'd0);
    assign tx_busy = (tx_state_q != TX_IDLE);

    // Receiver results seen by the register file
    logic [7:0] rx_byte;
    logic       rx_valid, rx_overrun;

    // Read data mux, sampled in the request cycle so it is stable during ack
    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            2'd1:    rd_mux = {24'd0, rx_byte};
            2'd2:    rd_mux = {27'd0, tx_busy, rx_overrun, rx_valid, tx_empty, tx_full};
            2'd3:    rd_mux = {16'd0, div_q};
            default: rd_mux = 32'd0;
        endcase
    end

    // Single-cycle ack and registered read data
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q     <= 1'b0;
            rd_data_q <= 32'd0;
        end else begin
            ack_q <= bus_req & ~ack_q;
            if (bus_req & ~ack_q) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    // Baud divisor; zero would stall the bit counter so it is clamped to one
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_q <= DIV_RESET;
        end else if (wr_cycle && reg_sel == 2'd3) begin
            div_q <= (wb.wb_dat_i[15:0] == 16'd0) ? 16'd1 : wb.wb_dat_i[15:0];
        end
    end

    // FIFO storage needs no reset; only the pointers define its contents
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wb.wb_dat_i[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + TX_DEPTH_LOG2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + TX_DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (TX_DEPTH_LOG2 + 1)'(1);
                2'b01:   count_q <= count_q - (TX_DEPTH_LOG2 + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // TX state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_state_q <= TX_IDLE;
            baud_q     <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
        end else begin
            tx_state_q <= tx_state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // TX next state; the divisor is reloaded at each bit boundary and the
    // stop bit chains straight into the next start bit when data is waiting
    always_comb begin
        tx_state_d = tx_state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_mem[rd_ptr_q];
                    baud_d     = div_q - 16'd1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    baud_d     = div_q - 16'd1;
                    bit_idx_d  = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_d    = div_q - 16'd1;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (!tx_empty) begin
                        pop        = 1'b1;
                        shift_d    = fifo_mem[rd_ptr_q];
                        baud_d     = div_q - 16'd1;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Line level follows the state directly, so reset forces idle-high at once
    always_comb begin
        tx_o = 1'b1;
        case (tx_state_q)
            TX_START: tx_o = 1'b0;
            TX_DATA:  tx_o = shift_q[0];
            default:  tx_o = 1'b1;
        endcase
    end

    // Registered interrupt level
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            irq_o <= 1'b1;
        end else begin
            irq_o <= tx_empty | rx_valid;
        end
    end

`ifdef MUSKOKA_UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_done;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q;
    logic        rx_valid_q, rx_overrun_q;
    logic        unused_bits;

    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
    assign unused_bits = &{1'b0, wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                           wb.wb_dat_i[31:16]};

    // Input synchroniser, edge history and RX state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_idx_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    // RX next state: half a bit to mid-start, then one full bit per sample
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = {1'b0, div_q[15:1]};
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_cnt_d   = div_q - 16'd1;
                    rx_idx_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_cnt_d = div_q - 16'd1;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_idx_d = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_done    = rx_s2_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Received byte holding register; a new byte wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_byte_q  <= rx_sh_q;
                rx_valid_q <= 1'b1;
            end else if (rd_cycle && reg_sel == 2'd1) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_done && rx_valid_q) begin
                rx_overrun_q <= 1'b1;
            end else if (rd_cycle && reg_sel == 2'd2) begin
                rx_overrun_q <= 1'b0;
            end
        end
    end
`else
    logic unused_bits;

    assign rx_byte    = 8'd0;
    assign rx_valid   = 1'b0;
    assign rx_overrun = 1'b0;
    assign unused_bits = &{1'b0, wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                           wb.wb_dat_i[31:16], rx_i, rd_cycle};
`endif

endmodule

// File: tb/tb_wb_uart.sv
// tb/tb_wb_uart.sv - directed self-checking bench for wb_uart
module tb_wb_uart;
    localparam logic [3:0] A_TX = 4'h0, A_RX = 4'h4, A_ST = 4'h8, A_DIV = 4'hC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tx, irq;
    int   checks = 0;
    int   failures = 0;
    int   mon_div = 4;
    bit   mon_en = 1'b0;
    logic [7:0] rxq [$];

    wb_uart_if bus();

    wb_uart dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .wb    (bus),
        .tx_o  (tx),
        .rx_i  (rx),
        .irq_o (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int n;
        n = 0;
        @(negedge clk);
        bus.wb_adr_i = {28'h0000200, adr};
        bus.wb_dat_i = wdata;
        bus.wb_we_i  = we;
        bus.wb_sel_i = 2'b11;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        while (n < 8) begin
            @(posedge clk); #1;
            n++;
            if (bus.wb_ack_o === 1'b1) break;
        end
        check("ack_latency", n, 1);
        rdata = bus.wb_dat_o;
        @(posedge clk); #1;
        check("ack_single_cycle", bus.wb_ack_o, 0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] d);
        logic [31:0] unused_r;
        bus_xfer(1'b1, adr, d, unused_r);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        bus_xfer(1'b0, adr, 32'd0, r);
        check(tag, r, exp);
    endtask

    // Called right after a TXDATA write returns: line must fall on the next edge
    task automatic check_frame(input logic [7:0] b, input int d);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        check("pre_start_idle", tx, 1);
        for (int i = 0; i < 10 * d; i++) begin
            @(posedge clk); #1;
            check($sformatf("frame_%02h_cyc%0d", b, i), tx, f[i / d]);
        end
        @(posedge clk); #1;
        check("post_frame_idle", tx, 1);
    endtask

`ifdef MUSKOKA_UART_RX_EN
    task automatic send_rx(input logic [7:0] b, input int d);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (d) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask
`endif

    // Line monitor: samples each frame at mid-bit and queues the byte
    initial forever begin
        logic [7:0] b;
        @(negedge tx);
        if (mon_en) begin
            repeat (mon_div / 2) @(posedge clk);
            #1;
            check("mon_start_bit", tx, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (mon_div) @(posedge clk);
                #1;
                b[i] = tx;
            end
            repeat (mon_div) @(posedge clk);
            #1;
            check("mon_stop_bit", tx, 1);
            rxq.push_back(b);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        time t_f1;
        bus.wb_adr_i = 32'd0;
        bus.wb_dat_i = 32'd0;
        bus.wb_sel_i = 2'b00;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_irq", irq, 1);
        check("rst_ack", bus.wb_ack_o, 0);
        check("rst_dat", bus.wb_dat_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("rst_status", A_ST, 32'h2);
        rd_check("rst_div", A_DIV, 32'h1B2);
        rd_check("txdata_reads_zero", A_TX, 32'h0);
        rd_check("rst_rxdata", A_RX, 32'h0);

        // 0x55 at divisor 4, exact bit timing
        mon_div = 4;
        mon_en  = 1'b1;
        wr(A_DIV, 32'd4);
        rd_check("div_4", A_DIV, 32'd4);
        wr(A_TX, 32'h55);
        check_frame(8'h55, 4);
        check("mon_count_55", rxq.size(), 1);
        if (rxq.size() > 0) check("mon_byte_55", rxq[0], 8'h55);
        rxq.delete();
        rd_check("idle_status", A_ST, 32'h2);

        // Asynchronous reset in the middle of the data bits
        mon_en = 1'b0;
        wr(A_TX, 32'hAA);
        repeat (6) @(posedge clk);
        #1;
        check("mid_frame_bit0_low", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_tx_high", tx, 1);
        check("async_reset_irq", irq, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("post_reset_status", A_ST, 32'h2);
        rd_check("post_reset_div", A_DIV, 32'h1B2);

        // Fill the FIFO at divisor 16; a write at full with no pop is dropped
        wr(A_DIV, 32'd16);
        mon_div = 16;
        mon_en  = 1'b1;
        for (int i = 0; i < 9; i++) wr(A_TX, i);
        rd_check("status_full", A_ST, 32'h11);
        check("irq_low_nonempty", irq, 0);
        wr(A_TX, 32'hEE);
        rd_check("status_full_after_drop", A_ST, 32'h11);

        n = 0;
        while (rxq.size() < 1 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("frame0_received", rxq.size() >= 1, 1);
        n = 0;
        while (n < 64) begin
            @(posedge clk); #1;
            n++;
            if (tx === 1'b0) break;
        end
        check("frame1_start_seen", tx, 0);
        t_f1 = $time - 1;
        wr(A_TX, 32'h09);
        rd_check("status_refilled", A_ST, 32'h11);

        // Push committed on exactly the edge where frame 2 pops its byte
        while ($time < t_f1 + 1580) @(posedge clk);
        wr(A_TX, 32'h0A);
        check("coincident_pop_start", tx, 0);
        rd_check("status_full_coincident", A_ST, 32'h11);

        n = 0;
        while (rxq.size() < 11 && n < 2500) begin
            @(posedge clk);
            n++;
        end
        repeat (40) @(posedge clk);
        check("frame_count", rxq.size(), 11);
        for (int i = 0; i < 11; i++) begin
            if (i < rxq.size()) check($sformatf("frame_order_%0d", i), rxq[i], i);
        end
        rxq.delete();
        rd_check("drained_status", A_ST, 32'h2);
        check("irq_high_empty", irq, 1);

        // Divisor 0 clamps to 1: ten-clock frame
        wr(A_DIV, 32'd0);
        rd_check("div_zero_clamped", A_DIV, 32'd1);
        mon_div = 1;
        wr(A_TX, 32'h3C);
        check_frame(8'h3C, 1);
        repeat (2) @(posedge clk);
        check("mon_count_3c", rxq.size(), 1);
        if (rxq.size() > 0) check("mon_byte_3c", rxq[0], 8'h3C);

`ifdef MUSKOKA_UART_RX_EN
        // Receiver: single byte, then overrun
        wr(A_DIV, 32'd8);
        send_rx(8'hA3, 8);
        rd_check("rx_valid_set", A_ST, 32'h6);
        check("irq_rx_valid", irq, 1);
        rd_check("rx_data_a3", A_RX, 32'hA3);
        rd_check("rx_valid_cleared", A_ST, 32'h2);
        send_rx(8'h11, 8);
        send_rx(8'h22, 8);
        rd_check("rx_overrun_set", A_ST, 32'hE);
        rd_check("rx_overrun_cleared", A_ST, 32'h6);
        rd_check("rx_data_second", A_RX, 32'h22);
        rd_check("rx_all_clear", A_ST, 32'h2);
`else
        // Without the receiver, rx_i activity is invisible
        rx = 1'b0;
        repeat (40) @(posedge clk);
        rd_check("no_rx_status", A_ST, 32'h2);
        rd_check("no_rx_data", A_RX, 32'h0);
        check("no_rx_irq", irq, 1);
        rx = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
